// File: rtl/halve_tokens_pkg.sv
// Shared definitions for the serial token halver: default capacity,
// counter-width helper and the run-detector state encoding.
package halve_tokens_pkg;

  localparam int DEFAULT_MAX_TOKENS = 200;

  // Counters must hold 2*max ones in a run plus headroom for the
  // pending-sum comparison, hence 2*max+2 distinct values.
  function automatic int cnt_w(input int max_tokens);
    return $clog2(2 * max_tokens + 2);
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/halve_tokens_run_length_counter.sv
// Run-length counter for the token halver.
// state | meaning
// IDLE  | no run in progress, count is zero
// RUN   | counting consecutive ones; a=0 here ends the run
// run_end pulses combinationally in the cycle a drops so the top level can
// fold the run into pending in that same cycle; run_len is valid with it.
module run_length_counter
  import halve_tokens_pkg::*;
#(
  parameter int MAX_TOKENS = DEFAULT_MAX_TOKENS,
  parameter int CNT_W      = cnt_w(DEFAULT_MAX_TOKENS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             run_end,
  output logic [CNT_W-1:0] run_len,
  output logic             sat
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(2 * MAX_TOKENS);

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Next-state and counter update; the count holds at RUN_MAX once saturated.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (a) begin
          state_d = RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      RUN: begin
        if (a) begin
          if (cnt_q != RUN_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    sat_d = (cnt_d == RUN_MAX);
  end

  // State, count and registered saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign run_end = (state_q == RUN) && !a;
  assign run_len = cnt_q;
  assign sat     = sat_q;

endmodule

// File: rtl/halve_tokens.sv
// Serial token halver: each run of N ones on a becomes N/2 ones on b.
// Optional feature macro: HALVE_TOKENS_CARRY_EN carries the odd remainder of
// a run into the next run instead of flagging it on odd_error.
module halve_tokens
  import halve_tokens_pkg::*;
#(
  parameter int MAX_TOKENS = DEFAULT_MAX_TOKENS
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic b,
  output logic overflow,
  output logic odd_error
);

  localparam int CNT_W = cnt_w(MAX_TOKENS);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'(MAX_TOKENS);

  logic             run_end;
  logic [CNT_W-1:0] run_len;
  logic             sat;

  run_length_counter #(
    .MAX_TOKENS (MAX_TOKENS),
    .CNT_W      (CNT_W)
  ) u_run_cnt (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .run_end (run_end),
    .run_len (run_len),
    .sat     (sat)
  );

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             carry;
  logic             b_now;
  logic [SUM_W-1:0] total;
  logic [SUM_W-1:0] add;
  logic [SUM_W-1:0] sum;

  // Fold a finished run into pending while draining one token per b cycle;
  // clamp and flag when the backlog would exceed capacity.
  always_comb begin
    b_now      = (pending_q != '0);
    total      = SUM_W'(run_len) + SUM_W'(carry);
    add        = run_end ? (total >> 1) : '0;
    sum        = SUM_W'(pending_q) + add - SUM_W'(b_now);
    overflow_d = overflow_q;
    if (sum > PEND_MAX) begin
      pending_d  = PEND_MAX[CNT_W-1:0];
      overflow_d = 1'b1;
    end else begin
      pending_d = sum[CNT_W-1:0];
    end
    if (a && sat) overflow_d = 1'b1;
  end

  // Pending backlog and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef HALVE_TOKENS_CARRY_EN
  logic carry_q, carry_d;

  // Remember the odd remainder of the run just ended.
  always_comb begin
    carry_d = carry_q;
    if (run_end) carry_d = total[0];
  end

  // Carry register.
  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign carry     = carry_q;
  assign odd_error = 1'b0;
`else
  logic odd_q, odd_d;

  // An odd-length run means a token was lost on the doubled link.
  always_comb begin
    odd_d = odd_q;
    if (run_end && run_len[0]) odd_d = 1'b1;
  end

  // Sticky odd-run flag.
  always_ff @(posedge clk) begin
    if (rst) odd_q <= 1'b0;
    else     odd_q <= odd_d;
  end

  assign carry     = 1'b0;
  assign odd_error = odd_q;
`endif

  assign b        = b_now;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_halve_tokens.sv
// Bench for halve_tokens: integer reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_halve_tokens;

  localparam int MAX = 200;
`ifdef HALVE_TOKENS_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic clk, rst, a;
  logic b, overflow, odd_error;

  halve_tokens #(.MAX_TOKENS(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .overflow  (overflow),
    .odd_error (odd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int b_seen = 0;
  bit model_valid = 1'b0;

  // model state: ones seen in the current run, tokens owed, remainder, flags
  int m_run, m_pend, m_carry;
  bit m_ovf, m_odd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock given the inputs sampled on that edge.
  task automatic model_step(input bit a_in, input bit rst_in);
    int owed, p;
    bit draining;
    if (rst_in) begin
      m_run = 0; m_pend = 0; m_carry = 0; m_ovf = 0; m_odd = 0;
      return;
    end
    draining = (m_pend > 0);
    if (a_in) begin
      if (m_run == 2 * MAX) m_ovf = 1;
      else m_run = m_run + 1;
      if (draining) m_pend = m_pend - 1;
    end else if (m_run > 0) begin
      owed = (m_run + m_carry) / 2;
      if (CARRY_EN) m_carry = (m_run + m_carry) % 2;
      else if (m_run % 2 == 1) m_odd = 1;
      m_run = 0;
      p = m_pend + owed - (draining ? 1 : 0);
      if (p > MAX) begin
        m_ovf = 1;
        p = MAX;
      end
      m_pend = p;
    end else if (draining) begin
      m_pend = m_pend - 1;
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("b", {31'd0, b}, (m_pend != 0) ? 32'd1 : 32'd0);
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("odd_error", {31'd0, odd_error}, {31'd0, m_odd});
      if (b === 1'b1) b_seen++;
    end
  end

  task automatic step(input bit av, input bit rv);
    @(posedge clk);
    #1;
    model_step(a, rst);
    model_valid = 1'b1;
    a = av;
    rst = rv;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    b_seen = 0;
  endtask

  initial begin
    a = 1'b0;
    rst = 1'b1;
    do_reset();
    chk("reset_b", {31'd0, b}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_odd", {31'd0, odd_error}, 32'd0);

    // 1: four ones -> two b cycles, first two cycles after the last one
    ones(4);
    step(1'b0, 1'b0);
    chk("t1_b_before", {31'd0, b}, 32'd0);
    step(1'b0, 1'b0);
    chk("t1_b_first", {31'd0, b}, 32'd1);
    zeros(6);
    chk("t1_b_count", b_seen, 32'd2);
    chk("t1_flags", {30'd0, overflow, odd_error}, 32'd0);

    // 2: back-to-back runs of two
    do_reset();
    ones(2); step(1'b0, 1'b0); ones(2); zeros(8);
    chk("t2_b_count", b_seen, 32'd2);
    chk("t2_b_idle", {31'd0, b}, 32'd0);

    // 3: odd run, then a run of one
    do_reset();
    ones(3); zeros(6);
    chk("t3_b_count", b_seen, 32'd1);
    chk("t3_odd", {31'd0, odd_error}, CARRY_EN ? 32'd0 : 32'd1);
    ones(1); zeros(6);
    chk("t3_b_total", b_seen, CARRY_EN ? 32'd2 : 32'd1);
    chk("t3_odd_held", {31'd0, odd_error}, CARRY_EN ? 32'd0 : 32'd1);

    // 4: 401 ones -> overflow, 200 output tokens
    do_reset();
    ones(400);
    step(1'b1, 1'b0);
    chk("t4_no_ovf_at_400", {31'd0, overflow}, 32'd0);
    step(1'b0, 1'b0);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    zeros(230);
    chk("t4_b_count", b_seen, 32'd200);
    chk("t4_ovf_held", {31'd0, overflow}, 32'd1);

    // 5: 110 pattern for ~1000 cycles
    do_reset();
    for (int i = 0; i < 333; i++) begin
      ones(2);
      step(1'b0, 1'b0);
    end
    zeros(10);
    chk("t5_b_count", b_seen, 32'd333);
    chk("t5_ovf", {31'd0, overflow}, 32'd0);

    // 6: reset mid-run and mid-drain
    do_reset();
    ones(5);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("t6_b_after_rst", {31'd0, b}, 32'd0);
    b_seen = 0;
    ones(2); zeros(5);
    chk("t6_b_count_run", b_seen, 32'd1);
    ones(20); zeros(5);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("t6_b_mid_drain", {31'd0, b}, 32'd0);
    chk("t6_flags", {30'd0, overflow, odd_error}, 32'd0);
    b_seen = 0;
    ones(2); zeros(5);
    chk("t6_b_count_drain", b_seen, 32'd1);

    // random runs and gaps, occasional reset, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int len, gap;
      len = $urandom_range(0, 12);
      if ($urandom_range(0, 40) == 0) len = $urandom_range(380, 402);
      gap = $urandom_range(1, 4);
      ones(len);
      if ($urandom_range(0, 60) == 0) step(1'b0, 1'b1);
      zeros(gap);
    end
    zeros(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
